// File: rtl/calc_ctrl.sv
// calc_ctrl: sequencing controller for the UART calculator. Builds decimal operands
// from digit pulses, launches the ALU on '=', and offers the result over valid/ready.
module calc_ctrl #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             num_done,
  input  logic [7:0]       num_i,
  input  logic             oper_done,
  input  logic [3:0]       oper_i,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [2*W-1:0]   alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*W-1:0]   res_o,
  output logic [1:0]       res_err
);

  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_WAIT = 2'd2, S_OUT = 2'd3} state_t;

  localparam logic [3:0]     OP_ADD   = 4'b0000;
  localparam logic [3:0]     OP_MOD   = 4'b0100;
  localparam logic [3:0]     OP_DIV   = 4'b1000;
  localparam logic [3:0]     OP_EQ    = 4'b1111;
  localparam logic [1:0]     ERR_NONE = 2'b00;
  localparam logic [1:0]     ERR_DIV0 = 2'b01;
  localparam logic [1:0]     ERR_OVF  = 2'b10;
  localparam logic [W-1:0]   ZERO_W   = {W{1'b0}};
  localparam logic [2*W-1:0] ZERO_R   = {(2*W){1'b0}};

  state_t         state_r;
  logic           a_seen_r;
  logic           b_seen_r;
  logic           has_res_r;

  logic [W-1:0]   acc_in_s;
  logic [W+3:0]   acc_ext_s;
  logic [W+3:0]   acc_next_s;
  logic           acc_ovf_s;
  logic           res_wide_s;
  logic           op_arith_s;
  logic           div_zero_s;

  function automatic logic is_arith(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: is_arith = 1'b1;
      default:                                     is_arith = 1'b0;
    endcase
  endfunction

  // Next decimal accumulator value for whichever operand the current state is building
  always_comb begin
    acc_in_s   = (state_r == S_B) ? alu_b : alu_a;
    acc_ext_s  = {4'b0000, acc_in_s};
    acc_next_s = (acc_ext_s << 2'd3) + (acc_ext_s << 1'd1) + {{(W-4){1'b0}}, num_i};
    acc_ovf_s  = |acc_next_s[W+3:W];
    // A chained result is only usable as operand A if it fits in W unsigned bits
    res_wide_s = |res_o[2*W-1:W];
    op_arith_s = is_arith(oper_i);
    div_zero_s = ((alu_op == OP_MOD) || (alu_op == OP_DIV)) && (alu_b == ZERO_W);
  end

  // Controller state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_A;
      alu_a     <= ZERO_W;
      alu_b     <= ZERO_W;
      alu_op    <= OP_ADD;
      alu_start <= 1'b0;
      res_valid <= 1'b0;
      res_o     <= ZERO_R;
      res_err   <= ERR_NONE;
      a_seen_r  <= 1'b0;
      b_seen_r  <= 1'b0;
      has_res_r <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (state_r)
        S_A: begin
          if (num_done) begin
            has_res_r <= 1'b0;
            if (acc_ovf_s) begin
              state_r   <= S_OUT;
              res_valid <= 1'b1;
              res_err   <= ERR_OVF;
              res_o     <= ZERO_R;
            end else begin
              alu_a    <= acc_next_s[W-1:0];
              a_seen_r <= 1'b1;
            end
          end else if (oper_done && op_arith_s) begin
            if (a_seen_r) begin
              alu_op   <= oper_i;
              alu_b    <= ZERO_W;
              b_seen_r <= 1'b0;
              state_r  <= S_B;
            end else if (has_res_r) begin
              if (res_wide_s) begin
                state_r   <= S_OUT;
                res_valid <= 1'b1;
                res_err   <= ERR_OVF;
                res_o     <= ZERO_R;
              end else begin
                alu_a    <= res_o[W-1:0];
                alu_op   <= oper_i;
                alu_b    <= ZERO_W;
                b_seen_r <= 1'b0;
                state_r  <= S_B;
              end
            end
          end
        end
        S_B: begin
          if (num_done) begin
            if (acc_ovf_s) begin
              state_r   <= S_OUT;
              res_valid <= 1'b1;
              res_err   <= ERR_OVF;
              res_o     <= ZERO_R;
            end else begin
              alu_b    <= acc_next_s[W-1:0];
              b_seen_r <= 1'b1;
            end
          end else if (oper_done) begin
            if (oper_i == OP_EQ) begin
              if (b_seen_r) begin
                if (div_zero_s) begin
                  state_r   <= S_OUT;
                  res_valid <= 1'b1;
                  res_err   <= ERR_DIV0;
                  res_o     <= ZERO_R;
                end else begin
                  alu_start <= 1'b1;
                  state_r   <= S_WAIT;
                end
              end
            end else if (op_arith_s && !b_seen_r) begin
              alu_op <= oper_i;
            end
          end
        end
        S_WAIT: begin
          // The launch cycle itself never completes, so the ALU always has >=1 cycle latency
          if (alu_done && !alu_start) begin
            res_o     <= alu_result;
            res_err   <= ERR_NONE;
            res_valid <= 1'b1;
            state_r   <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            alu_a     <= ZERO_W;
            alu_b     <= ZERO_W;
            a_seen_r  <= 1'b0;
            b_seen_r  <= 1'b0;
            has_res_r <= (res_err == ERR_NONE);
            if (res_err != ERR_NONE) begin
              res_o <= ZERO_R;
            end
            state_r   <= S_A;
          end
        end
        default: begin
          state_r <= S_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: expected launches and results are queued as
// stimulus is driven and compared when the DUT starts the ALU or offers a result.
module tb_calc_ctrl;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           num_done = 1'b0;
  logic [7:0]     num_i = 8'd0;
  logic           oper_done = 1'b0;
  logic [3:0]     oper_i = 4'd0;
  logic           alu_done = 1'b0;
  logic [2*W-1:0] alu_result = 32'd0;
  logic           res_ready = 1'b1;
  logic [W-1:0]   alu_a, alu_b;
  logic [3:0]     alu_op;
  logic           alu_start, res_valid;
  logic [2*W-1:0] res_o;
  logic [1:0]     res_err;

  int             n_checks = 0;
  int             n_pass = 0;
  int             n_starts = 0;
  int             alu_cnt = 0;
  logic [31:0]    alu_pend = 32'd0;
  logic [63:0]    launch_q[$];
  logic [63:0]    res_q[$];

  calc_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .num_done(num_done), .num_i(num_i),
    .oper_done(oper_done), .oper_i(oper_i),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_o(res_o), .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ALU model (3-cycle latency) plus launch/result scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    logic [31:0] ea, eb;
    alu_done = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        alu_done   = 1'b1;
        alu_result = alu_pend;
      end
    end
    if (alu_start) begin
      n_starts++;
      check_val("launch_expected", 64'(launch_q.size() != 0), 64'd1);
      if (launch_q.size() != 0)
        check_val("launch_operands", {28'd0, alu_a, alu_b, alu_op}, launch_q.pop_front());
      ea = {16'd0, alu_a};
      eb = {16'd0, alu_b};
      case (alu_op)
        4'b0000: alu_pend = ea + eb;
        4'b0001: alu_pend = ea - eb;
        4'b0010: alu_pend = ea * eb;
        4'b0100: alu_pend = (eb != 32'd0) ? ea % eb : 32'd0;
        4'b1000: alu_pend = (eb != 32'd0) ? ea / eb : 32'd0;
        default: alu_pend = 32'd0;
      endcase
      alu_cnt = 3;
    end
    if (res_valid && res_ready) begin
      check_val("result_expected", 64'(res_q.size() != 0), 64'd1);
      if (res_q.size() != 0)
        check_val("result", {30'd0, res_err, res_o}, res_q.pop_front());
    end
  end

  task automatic digit(input int d);
    num_i = 8'(d);
    num_done = 1'b1;
    @(negedge clk);
    num_done = 1'b0;
  endtask

  task automatic op(input logic [3:0] o);
    oper_i = o;
    oper_done = 1'b1;
    @(negedge clk);
    oper_done = 1'b0;
  endtask

  task automatic expect_calc(input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] o, input logic [31:0] r);
    launch_q.push_back({28'd0, a, b, o});
    res_q.push_back({30'd0, 2'b00, r});
  endtask

  task automatic drain();
    int n = 0;
    while ((res_q.size() != 0 || launch_q.size() != 0) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("drain_in_time", 64'(n < 100), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_alu"}, {27'd0, alu_a, alu_b, alu_op, alu_start}, 64'd0);
    check_val({tag, "_res"}, {29'd0, res_valid, res_err, res_o}, 64'd0);
  endtask

  initial begin
    int s0;
    int n;
    bit saw;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // 12 + 34 = 46
    expect_calc(16'd12, 16'd34, 4'b0000, 32'd46);
    digit(1); digit(2); op(4'b0000); digit(3); digit(4); op(4'b1111);
    drain();

    // Chain on previous result: 46 - 6
    expect_calc(16'd46, 16'd6, 4'b0001, 32'd40);
    op(4'b0001); digit(6); op(4'b1111);
    drain();

    // Operator replaced before B digit; operator after B digit ignored
    expect_calc(16'd5, 16'd3, 4'b0010, 32'd15);
    digit(5); op(4'b0000); op(4'b0010); digit(3); op(4'b0001); op(4'b1111);
    drain();

    // Divide by zero: no launch, error visible the cycle after '='
    s0 = n_starts;
    res_q.push_back({30'd0, 2'b01, 32'd0});
    digit(7); op(4'b1000); digit(0); op(4'b1111);
    check_val("div0_flag", {61'd0, res_valid, res_err}, {61'd0, 1'b1, 2'b01});
    drain();
    check_val("div0_no_start", n_starts, s0);

    // Operand overflow on fifth digit of 65536
    s0 = n_starts;
    res_q.push_back({30'd0, 2'b10, 32'd0});
    digit(6); digit(5); digit(5); digit(3);
    check_val("ovf_partial_quiet", 64'(res_valid), 64'd0);
    digit(6);
    check_val("ovf_flag", {61'd0, res_valid, res_err}, {61'd0, 1'b1, 2'b10});
    drain();
    check_val("ovf_no_start", n_starts, s0);

    // After an error there is no chained result: bare operator and '=' are ignored
    expect_calc(16'd2, 16'd3, 4'b0010, 32'd6);
    op(4'b0000); op(4'b1111); digit(2); op(4'b0010); digit(3); op(4'b1111);
    drain();

    // Back-pressure: result held stable while res_ready is low
    res_ready = 1'b0;
    expect_calc(16'd9, 16'd1, 4'b0000, 32'd10);
    digit(9); op(4'b0000); digit(1); op(4'b1111);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("bp_valid_seen", 64'(res_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("bp_hold", {29'd0, res_valid, res_err, res_o}, {29'd0, 1'b1, 2'b00, 32'd10});
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    drain();
    check_val("bp_released", 64'(res_valid), 64'd0);

    // Reset while waiting on the ALU; its late completion must be ignored
    launch_q.push_back({28'd0, 16'd3, 16'd4, 4'b0000});
    digit(3); op(4'b0000); digit(4); op(4'b1111);
    check_val("rst_test_started", 64'(alu_start), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst_wait");
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) saw = 1'b1;
    end
    check_val("late_done_ignored", 64'(saw), 64'd0);
    check_val("start_count", n_starts, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the UART calculator. It sits between the ASCII-to-binary decoder and the ALU. It accumulates decimal digit pulses into operand A and operand B, latches the operator, and launches the ALU on `=`. It then holds the result (or an error code) for the result transmitter through a valid/ready handshake.

## Interface
Parameters:
- `W`, default 16: operand width in bits. The result width is 2W.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `num_done`  in  1  one-cycle pulse: `num_i` is valid
- `num_i`  in  8  decimal digit value, 0–9
- `oper_done`  in  1  one-cycle pulse: `oper_i` is valid
- `oper_i`  in  4  operator code: 0000 `+`, 0001 `-`, 0010 `*`, 0100 `%`, 1000 `/`, 1111 `=`
- `alu_a`  out  W  operand A to the ALU
- `alu_b`  out  W  operand B to the ALU
- `alu_op`  out  4  latched operator code
- `alu_start`  out  1  one-cycle launch pulse
- `alu_done`  in  1  one-cycle pulse: `alu_result` is valid
- `alu_result`  in  2W  ALU result, two's complement, passed through unchanged
- `res_valid`  out  1  result/error is available
- `res_ready`  in  1  transmitter accepts it
- `res_o`  out  2W  result; 0 when an error is reported
- `res_err`  out  2  00 ok, 01 divide/remainder by zero, 10 operand overflow

## Operation
- States: S_A, S_B, S_WAIT, S_OUT.
- Reset values: state S_A; `alu_a`, `alu_b` = 0; `alu_op` = 0; `alu_start` = 0; `res_valid` = 0; `res_o` = 0; `res_err` = 0; digit-seen flags = 0; `has_res` = 0.
- Digit accumulation applies in S_A (into A) and in S_B (into B).
  - On `num_done`: acc ← acc*10 + `num_i`, computed in W+4 bits.
  - If the value exceeds 2^W−1, go to S_OUT with `res_err`=10.
  - On accept, set that operand's digit-seen flag.
- S_A:
  - A digit clears `has_res`, then accumulates into A.
  - An arithmetic operator is accepted when A has a digit or `has_res` is set.
    - If no A digit and `has_res` is set, load A ← `res_o`[W-1:0]. If `res_o` ≥ 2^W, go to S_OUT with error 10 instead.
    - On accept: latch `alu_op`, clear B and its flag, go to S_B.
    - Otherwise the operator is ignored.
  - `=` is ignored.
- S_B:
  - Digits accumulate into B.
  - An arithmetic operator with no B digit replaces `alu_op`. With a B digit, it is ignored.
  - `=` with no B digit is ignored.
  - `=` with a B digit:
    - If `alu_op` is 0100 or 1000 and B = 0, go to S_OUT with `res_err`=01. No `alu_start` is issued.
    - Otherwise pulse `alu_start` and go to S_WAIT.
- S_WAIT:
  - All input pulses are dropped.
  - On `alu_done`: `res_o` ← `alu_result`, `res_err` ← 00, go to S_OUT.
- S_OUT:
  - `res_valid`=1. `res_o` and `res_err` are held stable.
  - On `res_valid && res_ready`:
    - Clear A, B and the flags.
    - Set `has_res` = (`res_err`==00). On error, set `res_o` to 0.
    - Go to S_A.
  - Input pulses are dropped.
- Simultaneous `num_done` and `oper_done`: the digit wins and the operator is dropped.
- `alu_a`, `alu_b` and `alu_op` are stable from the `alu_start` cycle until `alu_done`.

## Timing
- Input pulses are sampled at the clock edge. The register update is visible in the next cycle.
- `=` sampled at edge k:
  - `alu_start` is high in cycle k+1 only.
  - `alu_done` is ignored while `alu_start` is high, so the ALU latency is ≥1 cycle.
- `alu_done` sampled at edge m: `res_valid` is high from cycle m+1.
- Divide-by-zero or overflow detected at edge k: `res_valid` is high from cycle k+1.
- Handshake completes at edge n: `res_valid` is low in cycle n+1, and a digit is accepted at edge n+1.
- `rst` sampled high in any state, including S_WAIT and S_OUT:
  - All outputs take their reset values in the next cycle.
  - A pending `alu_done` is ignored.

## Test plan
- Digits 1,2, `+`, 3,4, `=`; ALU model returns 46 after 3 cycles:
  - `alu_a`=12, `alu_b`=34, `alu_op`=0000.
  - One `alu_start` pulse.
  - `res_o`=46, `res_err`=00.
- 7, `/`, 0, `=`:
  - No `alu_start`.
  - `res_valid` the next cycle with `res_err`=01, `res_o`=0.
- Digits 6,5,5,3,6 (W=16):
  - `res_err`=10 on the cycle after the fifth digit.
  - The earlier partial value 6553 is not launched.
- After result 46 is accepted, `-`, 6, `=`:
  - `alu_a`=46, `alu_op`=0001, `alu_b`=6.
- 5, `+`, `*`, 3, `=`:
  - `alu_op`=0010, `alu_b`=3.
  - A `*` sent after the 3 would be ignored.
- Back-pressure and reset:
  - Hold `res_ready`=0 for 10 cycles: `res_valid` and `res_o` stay stable.
  - Assert `rst` during S_WAIT: all outputs return to 0 the next cycle, and a late `alu_done` produces no `res_valid`.
